// File: rtl/reorder_buffer.sv
// Circular reorder buffer for the Tomasulo core.
// Issue allocates entries in program order. The CDB completes them out of order.
// The head entry retires in order, at most one per cycle.
// An entry's index is the rename tag that reservation stations wait on.
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_has_dest,
    input  logic [4:0]        alloc_rd,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic [TAG_W-1:0]  look_tag1,
    output logic              look_rdy1,
    output logic [DATA_W-1:0] look_data1,
    input  logic [TAG_W-1:0]  look_tag2,
    output logic              look_rdy2,
    output logic [DATA_W-1:0] look_data2,
    output logic              commit_valid,
    output logic              commit_we,
    output logic [4:0]        commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic [DEPTH-1:0]  dest_q, dest_d;
    logic [4:0]        rd_q   [DEPTH];
    logic [4:0]        rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic head_ready_s;
    logic alloc_fire_s;
    logic commit_fire_s;
    logic cdb_hit_s;

    // Lookup result {rdy, data}: a CDB broadcast of the tag wins over stored state.
    function automatic logic [DATA_W:0] lookup(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] res;
        if (cdb_valid && (cdb_tag == tag)) begin
            res = {1'b1, cdb_data};
        end else if (valid_q[tag] && done_q[tag]) begin
            res = {1'b1, data_q[tag]};
        end else begin
            res = {1'b0, {DATA_W{1'b0}}};
        end
        return res;
    endfunction

    // Handshake and event qualification; reset/flush cycles never retire an entry.
    always_comb begin
        head_ready_s  = valid_q[head_q] & done_q[head_q];
        alloc_ready   = (count_q != FULL_CNT);
        alloc_tag     = tail_q;
        count         = count_q;
        commit_valid  = head_ready_s & rst_n & ~flush;
        alloc_fire_s  = alloc_valid & alloc_ready;
        commit_fire_s = head_ready_s;
        cdb_hit_s     = cdb_valid & valid_q[cdb_tag];
    end

    // Retirement port: mirrors the head entry only while it is retiring.
    always_comb begin
        if (commit_valid) begin
            commit_we   = dest_q[head_q];
            commit_rd   = rd_q[head_q];
            commit_data = data_q[head_q];
            commit_tag  = head_q;
        end else begin
            commit_we   = 1'b0;
            commit_rd   = 5'd0;
            commit_data = {DATA_W{1'b0}};
            commit_tag  = {TAG_W{1'b0}};
        end
    end

    // Two independent operand lookup ports for the reservation stations.
    always_comb begin
        {look_rdy1, look_data1} = lookup(look_tag1);
        {look_rdy2, look_data2} = lookup(look_tag2);
    end

    // Next-state: flush empties the buffer, otherwise apply CDB, commit and alloc.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        dest_d  = dest_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            valid_d = {DEPTH{1'b0}};
            done_d  = {DEPTH{1'b0}};
            head_d  = {TAG_W{1'b0}};
            tail_d  = {TAG_W{1'b0}};
            count_d = {(TAG_W+1){1'b0}};
        end else begin
            // Results for entries that are not live are dropped.
            if (cdb_hit_s) begin
                data_d[cdb_tag] = cdb_data;
                done_d[cdb_tag] = 1'b1;
            end else begin
                data_d[cdb_tag] = data_q[cdb_tag];
            end
            if (commit_fire_s) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + TAG_W'(1);
            end else begin
                head_d = head_q;
            end
            // alloc_ready excludes a same-cycle commit, so tail never equals a live head here.
            if (alloc_fire_s) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                dest_d[tail_q]  = alloc_has_dest;
                rd_d[tail_q]    = alloc_rd;
                tail_d          = tail_q + TAG_W'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({alloc_fire_s, commit_fire_s})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= {DEPTH{1'b0}};
            done_q  <= {DEPTH{1'b0}};
            dest_q  <= {DEPTH{1'b0}};
            head_q  <= {TAG_W{1'b0}};
            tail_q  <= {TAG_W{1'b0}};
            count_q <= {(TAG_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= 5'd0;
                data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            dest_q  <= dest_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a table of per-cycle vectors plus
// hand-built sequences for wrap-around under full and flush.
module tb_reorder_buffer;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        av;
        logic        hd;
        logic [4:0]  rd;
        logic        cv;
        logic [2:0]  ctag;
        logic [31:0] cdata;
        logic [2:0]  lt1;
        logic [2:0]  lt2;
    } in_t;

    typedef struct {
        logic        rdy;
        logic [2:0]  tag;
        logic        cv;
        logic        we;
        logic [4:0]  crd;
        logic [31:0] cdat;
        logic [2:0]  ctg;
        logic [3:0]  cnt;
        logic        lr1;
        logic [31:0] ld1;
        logic        lr2;
        logic [31:0] ld2;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic        clk;
    logic        rst_n, flush, alloc_valid, alloc_ready, alloc_has_dest;
    logic [4:0]  alloc_rd;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [2:0]  look_tag1, look_tag2;
    logic        look_rdy1, look_rdy2;
    logic [31:0] look_data1, look_data2;
    logic        commit_valid, commit_we;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic [2:0]  commit_tag;
    logic [3:0]  count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  done_sh = 8'd0;
    string       label;
    vec_t        tab [28];

    reorder_buffer #(.DEPTH(8), .TAG_W(3), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_has_dest(alloc_has_dest), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .look_tag1(look_tag1), .look_rdy1(look_rdy1), .look_data1(look_data1),
        .look_tag2(look_tag2), .look_rdy2(look_rdy2), .look_data2(look_data2),
        .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
        .commit_data(commit_data), .commit_tag(commit_tag), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic in_t I(logic r, logic f, logic av, logic hd, logic [4:0] rd,
                              logic cv, logic [2:0] ct, logic [31:0] cd,
                              logic [2:0] l1, logic [2:0] l2);
        in_t x;
        x.rst_n = r; x.flush = f; x.av = av; x.hd = hd; x.rd = rd;
        x.cv = cv; x.ctag = ct; x.cdata = cd; x.lt1 = l1; x.lt2 = l2;
        return x;
    endfunction

    function automatic exp_t E(logic rdy, logic [2:0] tag, logic cv, logic we,
                               logic [4:0] crd, logic [31:0] cdat, logic [2:0] ctg,
                               logic [3:0] cnt, logic lr1, logic [31:0] ld1,
                               logic lr2, logic [31:0] ld2);
        exp_t x;
        x.rdy = rdy; x.tag = tag; x.cv = cv; x.we = we; x.crd = crd; x.cdat = cdat;
        x.ctg = ctg; x.cnt = cnt; x.lr1 = lr1; x.ld1 = ld1; x.lr2 = lr2; x.ld2 = ld2;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h at %0t", label, name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then clock.
    task automatic apply(input vec_t v);
        rst_n = v.i.rst_n; flush = v.i.flush; alloc_valid = v.i.av;
        alloc_has_dest = v.i.hd; alloc_rd = v.i.rd; cdb_valid = v.i.cv;
        cdb_tag = v.i.ctag; cdb_data = v.i.cdata; look_tag1 = v.i.lt1; look_tag2 = v.i.lt2;
        @(negedge clk);
        chk("alloc_ready",  {31'd0, alloc_ready},  {31'd0, v.e.rdy});
        chk("alloc_tag",    {29'd0, alloc_tag},    {29'd0, v.e.tag});
        chk("commit_valid", {31'd0, commit_valid}, {31'd0, v.e.cv});
        chk("commit_we",    {31'd0, commit_we},    {31'd0, v.e.we});
        chk("commit_rd",    {27'd0, commit_rd},    {27'd0, v.e.crd});
        chk("commit_data",  commit_data,           v.e.cdat);
        chk("commit_tag",   {29'd0, commit_tag},   {29'd0, v.e.ctg});
        chk("count",        {28'd0, count},        {28'd0, v.e.cnt});
        chk("look_rdy1",    {31'd0, look_rdy1},    {31'd0, v.e.lr1});
        chk("look_data1",   look_data1,            v.e.ld1);
        chk("look_rdy2",    {31'd0, look_rdy2},    {31'd0, v.e.lr2});
        chk("look_data2",   look_data2,            v.e.ld2);
        // A CDB write to an already-completed entry is a stimulus protocol error.
        if (v.i.cv && v.i.rst_n && !v.i.flush) begin
            checks++;
            if (done_sh[v.i.ctag]) begin
                errors++;
                $display("FAIL %s.cdb_protocol: tag %0d written twice", label, v.i.ctag);
            end
        end
        @(posedge clk);
        #1;
        if (!v.i.rst_n || v.i.flush) begin
            done_sh = 8'd0;
        end else begin
            if (v.i.cv) done_sh[v.i.ctag] = 1'b1;
            if (v.i.av && v.e.rdy) done_sh[v.e.tag] = 1'b0;
        end
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_has_dest = 1'b0;
        alloc_rd = 5'd0; cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 32'd0;
        look_tag1 = 3'd0; look_tag2 = 3'd0;
        label = "init";
        repeat (2) @(posedge clk);
        #1;

        // Reset state, fill to full, refused 9th alloc, CDB bypass, mid-op reset.
        tab[0] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd0,3'd0), E(1'b1,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd0,1'b0,32'h0,1'b0,32'h0)};
        for (int k = 1; k <= 8; k++) begin
            tab[k] = '{I(1'b1,1'b0,1'b1,1'b1,5'(k),1'b0,3'd0,32'h0,3'd0,3'd0),
                       E(1'b1,3'(k-1),1'b0,1'b0,5'd0,32'h0,3'd0,4'(k-1),1'b0,32'h0,1'b0,32'h0)};
        end
        tab[9]  = '{I(1'b1,1'b0,1'b1,1'b1,5'd9,1'b0,3'd0,32'h0,3'd0,3'd0),     E(1'b0,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd8,1'b0,32'h0,1'b0,32'h0)};
        tab[10] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd0,3'd0),     E(1'b0,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd8,1'b0,32'h0,1'b0,32'h0)};
        tab[11] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,3'd3,32'hABCD,3'd3,3'd4), E(1'b0,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd8,1'b1,32'hABCD,1'b0,32'h0)};
        tab[12] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,3'd0,32'h55,3'd3,3'd0),   E(1'b0,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd8,1'b1,32'hABCD,1'b1,32'h55)};
        tab[13] = '{I(1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd3,3'd0),     E(1'b0,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd8,1'b1,32'hABCD,1'b1,32'h55)};
        tab[14] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd3,3'd0),     E(1'b1,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd0,1'b0,32'h0,1'b0,32'h0)};
        // Out-of-order completion, in-order retirement.
        tab[15] = '{I(1'b1,1'b0,1'b1,1'b1,5'd10,1'b0,3'd0,32'h0,3'd0,3'd0),    E(1'b1,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd0,1'b0,32'h0,1'b0,32'h0)};
        tab[16] = '{I(1'b1,1'b0,1'b1,1'b1,5'd11,1'b0,3'd0,32'h0,3'd0,3'd0),    E(1'b1,3'd1,1'b0,1'b0,5'd0,32'h0,3'd0,4'd1,1'b0,32'h0,1'b0,32'h0)};
        tab[17] = '{I(1'b1,1'b0,1'b1,1'b1,5'd12,1'b0,3'd0,32'h0,3'd0,3'd0),    E(1'b1,3'd2,1'b0,1'b0,5'd0,32'h0,3'd0,4'd2,1'b0,32'h0,1'b0,32'h0)};
        tab[18] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,3'd2,32'h33,3'd2,3'd0),    E(1'b1,3'd3,1'b0,1'b0,5'd0,32'h0,3'd0,4'd3,1'b1,32'h33,1'b0,32'h0)};
        tab[19] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,3'd0,32'h11,3'd2,3'd0),    E(1'b1,3'd3,1'b0,1'b0,5'd0,32'h0,3'd0,4'd3,1'b1,32'h33,1'b1,32'h11)};
        tab[20] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,3'd1,32'h22,3'd1,3'd0),    E(1'b1,3'd3,1'b1,1'b1,5'd10,32'h11,3'd0,4'd3,1'b1,32'h22,1'b1,32'h11)};
        tab[21] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd0,3'd2),     E(1'b1,3'd3,1'b1,1'b1,5'd11,32'h22,3'd1,4'd2,1'b0,32'h0,1'b1,32'h33)};
        tab[22] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd0,3'd2),     E(1'b1,3'd3,1'b1,1'b1,5'd12,32'h33,3'd2,4'd1,1'b0,32'h0,1'b1,32'h33)};
        tab[23] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd0,3'd2),     E(1'b1,3'd3,1'b0,1'b0,5'd0,32'h0,3'd0,4'd0,1'b0,32'h0,1'b0,32'h0)};
        // Instruction without destination: retires with commit_we=0.
        tab[24] = '{I(1'b1,1'b0,1'b1,1'b0,5'd5,1'b0,3'd0,32'h0,3'd3,3'd0),     E(1'b1,3'd3,1'b0,1'b0,5'd0,32'h0,3'd0,4'd0,1'b0,32'h0,1'b0,32'h0)};
        tab[25] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,3'd3,32'h77,3'd3,3'd0),    E(1'b1,3'd4,1'b0,1'b0,5'd0,32'h0,3'd0,4'd1,1'b1,32'h77,1'b0,32'h0)};
        tab[26] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd3,3'd0),     E(1'b1,3'd4,1'b1,1'b0,5'd5,32'h77,3'd3,4'd1,1'b1,32'h77,1'b0,32'h0)};
        tab[27] = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd3,3'd0),     E(1'b1,3'd4,1'b0,1'b0,5'd0,32'h0,3'd0,4'd0,1'b0,32'h0,1'b0,32'h0)};

        for (int n = 0; n < 28; n++) begin
            label = $sformatf("vec%0d", n);
            apply(tab[n]);
        end

        // Full buffer: head completes, alloc stalls during the commit, then wraps to old head tag.
        label = "wrap_rst";
        v = '{I(1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd0,3'd0), E(1'b1,3'd4,1'b0,1'b0,5'd0,32'h0,3'd0,4'd0,1'b0,32'h0,1'b0,32'h0)};
        apply(v);
        for (int k = 0; k < 8; k++) begin
            label = $sformatf("wrap_fill%0d", k);
            v = '{I(1'b1,1'b0,1'b1,1'b1,5'(k+1),1'b0,3'd0,32'h0,3'd0,3'd0),
                  E(1'b1,3'(k),1'b0,1'b0,5'd0,32'h0,3'd0,4'(k),1'b0,32'h0,1'b0,32'h0)};
            apply(v);
        end
        label = "wrap_cdb";
        v = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,3'd0,32'hC0,3'd0,3'd7), E(1'b0,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd8,1'b1,32'hC0,1'b0,32'h0)};
        apply(v);
        label = "wrap_stall";
        v = '{I(1'b1,1'b0,1'b1,1'b1,5'd20,1'b0,3'd0,32'h0,3'd0,3'd7), E(1'b0,3'd0,1'b1,1'b1,5'd1,32'hC0,3'd0,4'd8,1'b1,32'hC0,1'b0,32'h0)};
        apply(v);
        label = "wrap_grant";
        v = '{I(1'b1,1'b0,1'b1,1'b1,5'd20,1'b0,3'd0,32'h0,3'd0,3'd7), E(1'b1,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd7,1'b0,32'h0,1'b0,32'h0)};
        apply(v);
        label = "wrap_full";
        v = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd0,3'd7), E(1'b0,3'd1,1'b0,1'b0,5'd0,32'h0,3'd0,4'd8,1'b0,32'h0,1'b0,32'h0)};
        apply(v);

        // Flush with 5 live entries (tags 0 and 3 done) plus a concurrent CDB write and alloc.
        label = "flush_rst";
        v = '{I(1'b0,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd0,3'd0), E(1'b0,3'd1,1'b0,1'b0,5'd0,32'h0,3'd0,4'd8,1'b0,32'h0,1'b0,32'h0)};
        apply(v);
        for (int k = 0; k < 5; k++) begin
            label = $sformatf("flush_fill%0d", k);
            v = '{I(1'b1,1'b0,1'b1,1'b1,5'(k+1),1'b0,3'd0,32'h0,3'd0,3'd0),
                  E(1'b1,3'(k),1'b0,1'b0,5'd0,32'h0,3'd0,4'(k),1'b0,32'h0,1'b0,32'h0)};
            apply(v);
        end
        label = "flush_cdb3";
        v = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,3'd3,32'h33,3'd3,3'd0), E(1'b1,3'd5,1'b0,1'b0,5'd0,32'h0,3'd0,4'd5,1'b1,32'h33,1'b0,32'h0)};
        apply(v);
        label = "flush_cdb0";
        v = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b1,3'd0,32'h11,3'd3,3'd0), E(1'b1,3'd5,1'b0,1'b0,5'd0,32'h0,3'd0,4'd5,1'b1,32'h33,1'b1,32'h11)};
        apply(v);
        label = "flush_cycle";
        v = '{I(1'b1,1'b1,1'b1,1'b1,5'd6,1'b1,3'd2,32'h99,3'd2,3'd3), E(1'b1,3'd5,1'b0,1'b0,5'd0,32'h0,3'd0,4'd5,1'b1,32'h99,1'b1,32'h33)};
        apply(v);
        label = "flush_after";
        v = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd2,3'd3), E(1'b1,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd0,1'b0,32'h0,1'b0,32'h0)};
        apply(v);
        label = "flush_alloc";
        v = '{I(1'b1,1'b0,1'b1,1'b1,5'd9,1'b0,3'd0,32'h0,3'd0,3'd0), E(1'b1,3'd0,1'b0,1'b0,5'd0,32'h0,3'd0,4'd0,1'b0,32'h0,1'b0,32'h0)};
        apply(v);
        label = "flush_end";
        v = '{I(1'b1,1'b0,1'b0,1'b0,5'd0,1'b0,3'd0,32'h0,3'd0,3'd0), E(1'b1,3'd1,1'b0,1'b0,5'd0,32'h0,3'd0,4'd1,1'b0,32'h0,1'b0,32'h0)};
        apply(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
